// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: arbitrates taken branches, load-use hazards and
// instruction-memory wait states into PC, IF/ID and ID/EX controls.
module fetch_sequencer #(
  parameter int FLUSH_DEPTH = 2,
  parameter int TIMEOUT     = 15,
  parameter int REG_W       = 5
) (
  input  logic             clock,
  input  logic             reset,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic             branch_taken,
  input  logic             branch_reg,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic [REG_W-1:0] if_id_rn,
  input  logic [REG_W-1:0] if_id_rm,
  output logic             PCWrite,
  output logic             or_out,
  output logic             Branchreg,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [15:0]      stall_count,
  output logic             fetch_timeout
);

  typedef enum logic [2:0] {
    RESET_HOLD,
    RUN,
    LOAD_STALL,
    REDIRECT,
    MEM_WAIT
  } state_t;

  localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);
  localparam logic [7:0]       TIMEOUT_CNT  = 8'(TIMEOUT);
  localparam logic [REG_W-1:0] XZR          = REG_W'(31);

  state_t     state, state_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       wait_step;
  logic       redirect;
  logic       load_use;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign redirect = branch_taken | branch_reg;
  // XZR reads as zero, so a load targeting it never creates a dependency
  assign load_use = id_ex_mem_read & (id_ex_rd != XZR) &
                    ((id_ex_rd == if_id_rn) | (id_ex_rd == if_id_rm));

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    wait_cnt_nxt  = wait_cnt;
    wait_step     = 1'b0;
    imem_req      = 1'b1;
    PCWrite       = 1'b1;
    or_out        = 1'b0;
    Branchreg     = 1'b0;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;

    if (state == RESET_HOLD) begin
      imem_req      = 1'b0;
      PCWrite       = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      state_nxt     = RUN;
      flush_cnt_nxt = '0;
      wait_cnt_nxt  = '0;
    end else if (redirect) begin
      // A redirect abandons any pending wait or load stall
      Branchreg    = branch_reg;
      or_out       = branch_taken & ~branch_reg;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      wait_cnt_nxt = '0;
      if (FLUSH_DEPTH > 1) begin
        state_nxt     = REDIRECT;
        flush_cnt_nxt = FLUSH_RELOAD;
      end else begin
        state_nxt     = RUN;
        flush_cnt_nxt = '0;
      end
    end else begin
      case (state)
        REDIRECT: begin
          if_id_flush = 1'b1;
          if (flush_cnt <= 3'd1) begin
            state_nxt     = RUN;
            flush_cnt_nxt = '0;
          end else begin
            flush_cnt_nxt = flush_cnt - 3'd1;
          end
        end
        MEM_WAIT: begin
          if (imem_ready) begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
          end else begin
            PCWrite      = 1'b0;
            if_id_flush  = 1'b1;
            wait_step    = 1'b1;
            wait_cnt_nxt = sat_inc8(wait_cnt);
          end
        end
        LOAD_STALL: begin
          if (imem_ready) begin
            state_nxt = RUN;
          end else begin
            PCWrite      = 1'b0;
            if_id_flush  = 1'b1;
            wait_step    = 1'b1;
            wait_cnt_nxt = 8'd1;
            state_nxt    = MEM_WAIT;
          end
        end
        default: begin
          if (load_use) begin
            PCWrite      = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            state_nxt    = LOAD_STALL;
          end else if (!imem_ready) begin
            PCWrite      = 1'b0;
            if_id_flush  = 1'b1;
            wait_step    = 1'b1;
            wait_cnt_nxt = 8'd1;
            state_nxt    = MEM_WAIT;
          end else begin
            state_nxt = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= RESET_HOLD;
      flush_cnt     <= '0;
      wait_cnt      <= '0;
      stall_count   <= '0;
      fetch_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      if (state != RESET_HOLD && !PCWrite)
        stall_count <= sat_inc16(stall_count);
      if (wait_step && wait_cnt_nxt == TIMEOUT_CNT)
        fetch_timeout <= 1'b1;
    end
  end

endmodule
